mpu: RTL and testbench
======================

MPU -- requirements
Module: mpu

Interface
REQ-001 Parameter SCL_QTR, default 125: system-clock cycles per quarter SCL period (100 kHz SCL at 50 MHz clk).
REQ-002 Parameter DEV_ADDR, default 7'h68: 7-bit I2C address of the MPU6050.
REQ-003 Parameter BURST_LEN, default 14: bytes per data transfer.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (port keeps the codebase name).
REQ-006 mpu_init  input  1  one-cycle pulse; starts the register-initialization sequence.
REQ-007 mpu_transfer  input  1  one-cycle pulse; starts a burst read of sensor data.
REQ-008 scl  output  1  I2C clock, driven push-pull by the master.
REQ-009 sda  inout  1  I2C data, open-drain: drive 0 or high-Z, never drive 1.
REQ-010 init_done  output  1  level; high once initialization has completed.
REQ-011 data_avalid  output  1  one-cycle strobe; data holds a valid received byte.
REQ-012 data  output  8  last received byte.
REQ-013 busy_now  output  1  high while any I2C transaction is in progress.

Function
REQ-014 States: IDLE, START, ADDR, REG, RESTART, RADDR, WRDATA, RDDATA, ACK, STOP, DONE; each bit occupies 4 quarter phases of SCL_QTR cycles.
REQ-015 START/RESTART: SDA falls while SCL is high. STOP: SDA rises while SCL is high. SDA changes only while SCL is low.
REQ-016 Init sequence: one write transaction per register, in this order: 0x6B=0x00, 0x19=0x07, 0x1A=0x06, 0x1B=0x18, 0x1C=0x01.
REQ-017 Each write frame: START, {DEV_ADDR,0}, ACK slot, register, ACK slot, value, ACK slot, STOP.
REQ-018 init_done rises one clk after the final STOP completes and stays high until reset.
REQ-019 Transfer frame: START, {DEV_ADDR,0}, reg 0x3B, RESTART, {DEV_ADDR,1}, then BURST_LEN bytes read MSB first.
REQ-020 Master sends ACK after each read byte except the last, which gets NACK, followed by STOP.
REQ-021 data_avalid pulses one clk after the 8th bit of each read byte is sampled; data stays stable until the next strobe.
REQ-022 SDA is sampled at the middle of the SCL-high phase.
REQ-023 busy_now goes high the clk after an accepted pulse and low the clk after STOP completes.
REQ-024 A pulse on mpu_init or mpu_transfer while busy_now=1 is ignored.
REQ-025 If both pulses arrive in the same cycle, mpu_init wins.
REQ-026 mpu_transfer is ignored while init_done=0.

Reset
REQ-027 On reset: state=IDLE, scl=1, sda released, init_done=0, data_avalid=0, data=8'h00, busy_now=0.
REQ-028 Reset mid-transaction aborts immediately with no STOP generated.

Configuration
REQ-029 Macro MPU_ACK_CHECK_EN defined: a NACK in any slave-ACK slot issues STOP, returns to IDLE and leaves init_done unchanged (init aborts with init_done=0).
REQ-030 Macro MPU_ACK_CHECK_EN undefined: slave-ACK slots are clocked but their value is ignored.

Structure
REQ-031 Package mpu_pkg holds the state enum, the register addresses (0x6B, 0x19, 0x1A, 0x1B, 0x1C, 0x3B) and the init value table.
REQ-032 One sub-module, mpu_i2c_bit: generates the SCL quarter-phase timing and performs START/STOP/bit-write/bit-read.
REQ-033 The top-level block sequences the transactions.

Verification
REQ-034 Reset, then mpu_init pulse with an ACKing slave model -> 5 write frames carrying the REQ-016 bytes; init_done=1 after the last STOP; busy_now=0.
REQ-035 mpu_transfer pulse after init, slave returns bytes 0x00..0x0D -> 14 data_avalid strobes with data 0x00..0x0D in order; master NACKs only byte 14.
REQ-036 mpu_transfer before init -> no SCL activity; busy_now stays 0.
REQ-037 mpu_init pulse while busy -> ignored; frame count unchanged.
REQ-038 With MPU_ACK_CHECK_EN, slave NACKs the address byte -> STOP issued, init_done=0, busy_now=0.
REQ-039 Reset asserted during the 3rd init frame -> all outputs return to REQ-027 values on the next clk.

Source files
------------

// File: rtl/mpu_pkg.sv
// MPU6050 I2C master: shared state encoding, bit-level commands, register map and init table.
package mpu_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, REG, RESTART, RADDR, WRDATA, RDDATA, ACK, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_START, CMD_STOP, CMD_WRITE, CMD_READ
  } bit_cmd_t;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_SMPLRT_DIV   = 8'h19;
  localparam logic [7:0] REG_CONFIG       = 8'h1A;
  localparam logic [7:0] REG_GYRO_CONFIG  = 8'h1B;
  localparam logic [7:0] REG_ACCEL_CONFIG = 8'h1C;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

  localparam int INIT_CNT = 5;

  // {register, value} written by the init sequence, in bus order
  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = {REG_PWR_MGMT_1,   8'h00};
      3'd1:    init_entry = {REG_SMPLRT_DIV,   8'h07};
      3'd2:    init_entry = {REG_CONFIG,       8'h06};
      3'd3:    init_entry = {REG_GYRO_CONFIG,  8'h18};
      default: init_entry = {REG_ACCEL_CONFIG, 8'h01};
    endcase
  endfunction

endpackage

// File: rtl/mpu_i2c_bit.sv
// I2C bit engine: executes one START/STOP/bit-write/bit-read as 4 quarter phases of SCL_QTR clks.
// Latency: done pulses the clk after the 4th quarter; rx_vld pulses at mid SCL-high of a read.
// Backpressure: none; cmd_vld is only honoured while idle, the caller waits for done.
module mpu_i2c_bit
  import mpu_pkg::*;
#(
  parameter int SCL_QTR = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vld,
  input  logic [1:0] cmd,
  input  logic       din,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       done,
  output logic       rx_vld,
  output logic       rx_bit
);

  localparam int CW = $clog2(SCL_QTR + 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [1:0]    cmd_r;
  logic          din_r;

  // {scl, sda_oe} per quarter; SDA only moves in quarter 0 or while SCL is held high for START/STOP
  function automatic logic [1:0] bus_drive(input logic [1:0] c, input logic [1:0] ph, input logic d);
    logic hi;
    hi = (ph == 2'd1) || (ph == 2'd2);
    case (c)
      CMD_START: bus_drive = {hi, ph >= 2'd2};
      CMD_STOP:  bus_drive = {ph != 2'd0, ph < 2'd2};
      CMD_WRITE: bus_drive = {hi, ~d};
      default:   bus_drive = {hi, 1'b0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      phase  <= 2'd0;
      cmd_r  <= CMD_STOP;
      din_r  <= 1'b1;
      scl    <= 1'b1;
      sda_oe <= 1'b0;
      done   <= 1'b0;
      rx_vld <= 1'b0;
      rx_bit <= 1'b1;
    end else begin
      done   <= 1'b0;
      rx_vld <= 1'b0;
      if (!active) begin
        if (cmd_vld) begin
          active          <= 1'b1;
          cnt             <= '0;
          phase           <= 2'd0;
          cmd_r           <= cmd;
          din_r           <= din;
          {scl, sda_oe}   <= bus_drive(cmd, 2'd0, din);
        end
      end else if (cnt == CW'(SCL_QTR - 1)) begin
        cnt <= '0;
        if (phase == 2'd1 && cmd_r == CMD_READ) begin
          rx_bit <= sda_in;
          rx_vld <= 1'b1;
        end
        if (phase == 2'd3) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          phase         <= phase + 2'd1;
          {scl, sda_oe} <= bus_drive(cmd_r, phase + 2'd1, din_r);
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu.sv
// MPU6050 I2C master: register init sequence and burst sensor read (MPU_ACK_CHECK_EN aborts on slave NACK).
// Latency: busy_now rises the clk after an accepted pulse, falls the clk after the final STOP.
// Backpressure: mpu_init/mpu_transfer pulses are dropped while busy; transfer needs init_done.
module mpu
  import mpu_pkg::*;
#(
  parameter int         SCL_QTR   = 125,
  parameter logic [6:0] DEV_ADDR  = 7'h68,
  parameter int         BURST_LEN = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mpu_init,
  input  logic       mpu_transfer,
  output logic       scl,
  inout  wire        sda,
  output logic       init_done,
  output logic       data_avalid,
  output logic [7:0] data,
  output logic       busy_now
);

  state_t      state;
  state_t      ack_from;
  logic        pend;
  logic        cmd_vld;
  logic [1:0]  cmd;
  logic        din;
  logic [1:0]  nxt_cmd;
  logic        nxt_din;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [2:0]  reg_idx;
  logic [7:0]  byte_cnt;
  logic        is_rd;
  logic        abort;
  logic        last_byte;
  logic [15:0] init_cur;
  logic        sda_oe;
  logic        bit_done;
  logic        rx_vld;
  logic        rx_bit;

  assign sda       = sda_oe ? 1'b0 : 1'bz;
  assign init_cur  = init_entry(reg_idx);
  assign last_byte = (byte_cnt == 8'(BURST_LEN - 1));

  mpu_i2c_bit #(.SCL_QTR(SCL_QTR)) u_bit (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_vld (cmd_vld),
    .cmd     (cmd),
    .din     (din),
    .sda_in  (sda),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .done    (bit_done),
    .rx_vld  (rx_vld),
    .rx_bit  (rx_bit)
  );

  // The ACK state either listens to the slave or, after a read byte, sends ACK/NACK itself
  always_comb begin
    nxt_cmd = CMD_WRITE;
    nxt_din = shreg[7];
    case (state)
      START, RESTART: nxt_cmd = CMD_START;
      STOP:           nxt_cmd = CMD_STOP;
      RDDATA:         nxt_cmd = CMD_READ;
      ACK: begin
        if (ack_from == RDDATA) nxt_din = last_byte;
        else                    nxt_cmd = CMD_READ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      ack_from    <= IDLE;
      pend        <= 1'b0;
      cmd_vld     <= 1'b0;
      cmd         <= CMD_STOP;
      din         <= 1'b1;
      shreg       <= 8'h00;
      bit_idx     <= 3'd0;
      reg_idx     <= 3'd0;
      byte_cnt    <= 8'd0;
      is_rd       <= 1'b0;
      abort       <= 1'b0;
      init_done   <= 1'b0;
      data_avalid <= 1'b0;
      data        <= 8'h00;
      busy_now    <= 1'b0;
    end else begin
      cmd_vld     <= 1'b0;
      data_avalid <= 1'b0;
      if (state != IDLE && state != DONE && !pend) begin
        cmd_vld <= 1'b1;
        pend    <= 1'b1;
        cmd     <= nxt_cmd;
        din     <= nxt_din;
      end
      if (state == RDDATA && rx_vld && bit_idx == 3'd0) begin
        data        <= {shreg[6:0], rx_bit};
        data_avalid <= 1'b1;
      end
      case (state)
        IDLE: begin
          abort <= 1'b0;
          if (mpu_init) begin
            is_rd    <= 1'b0;
            reg_idx  <= 3'd0;
            busy_now <= 1'b1;
            state    <= START;
          end else if (mpu_transfer && init_done) begin
            is_rd    <= 1'b1;
            byte_cnt <= 8'd0;
            busy_now <= 1'b1;
            state    <= START;
          end
        end
        DONE: state <= IDLE;
        default: if (pend && bit_done) begin
          pend <= 1'b0;
          case (state)
            START: begin
              shreg   <= {DEV_ADDR, 1'b0};
              bit_idx <= 3'd7;
              state   <= ADDR;
            end
            RESTART: begin
              shreg   <= {DEV_ADDR, 1'b1};
              bit_idx <= 3'd7;
              state   <= RADDR;
            end
            ADDR, REG, RADDR, WRDATA: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_idx <= bit_idx - 3'd1;
              if (bit_idx == 3'd0) begin
                ack_from <= state;
                state    <= ACK;
              end
            end
            RDDATA: begin
              shreg   <= {shreg[6:0], rx_bit};
              bit_idx <= bit_idx - 3'd1;
              if (bit_idx == 3'd0) begin
                ack_from <= RDDATA;
                state    <= ACK;
              end
            end
            ACK: begin
`ifdef MPU_ACK_CHECK_EN
              if (ack_from != RDDATA && rx_bit) begin
                abort <= 1'b1;
                state <= STOP;
              end else
`endif
              case (ack_from)
                ADDR: begin
                  shreg   <= is_rd ? REG_ACCEL_XOUT_H : init_cur[15:8];
                  bit_idx <= 3'd7;
                  state   <= REG;
                end
                REG: begin
                  if (is_rd) begin
                    state <= RESTART;
                  end else begin
                    shreg   <= init_cur[7:0];
                    bit_idx <= 3'd7;
                    state   <= WRDATA;
                  end
                end
                WRDATA: state <= STOP;
                RADDR: begin
                  bit_idx <= 3'd7;
                  state   <= RDDATA;
                end
                default: begin
                  byte_cnt <= byte_cnt + 8'd1;
                  bit_idx  <= 3'd7;
                  state    <= last_byte ? STOP : RDDATA;
                end
              endcase
            end
            STOP: begin
              if (!is_rd && !abort && reg_idx != 3'(INIT_CNT - 1)) begin
                reg_idx <= reg_idx + 3'd1;
                state   <= START;
              end else begin
                busy_now <= 1'b0;
                state    <= DONE;
                if (!is_rd && !abort) init_done <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu.sv
// Bench for mpu: I2C slave model, table-driven frame/data checks and hand-written reset/busy sequences.
`timescale 1ns/1ps
module tb_mpu;

  localparam int QTR = 4;

  typedef struct {
    logic [7:0] reg_a;
    logic [7:0] val;
  } wr_vec_t;

  typedef struct {
    logic [7:0] slv_byte;
    logic [7:0] exp_data;
    logic       exp_mack;
  } rd_vec_t;

  wr_vec_t wr_tab[5];
  rd_vec_t rd_tab[14];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mpu_init = 1'b0;
  logic mpu_transfer = 1'b0;
  logic scl, init_done, data_avalid, busy_now;
  logic [7:0] data;
  wire sda;
  logic slv_drv = 1'b0;

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  mpu #(.SCL_QTR(QTR), .DEV_ADDR(7'h68), .BURST_LEN(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mpu_init     (mpu_init),
    .mpu_transfer (mpu_transfer),
    .scl          (scl),
    .sda          (sda),
    .init_done    (init_done),
    .data_avalid  (data_avalid),
    .data         (data),
    .busy_now     (busy_now)
  );

  always #5 clk = ~clk;

  // Slave model: decodes START/STOP/bits, ACKs written bytes, serves rd_tab on reads
  int start_cnt = 0, stop_cnt = 0, scl_fall = 0, bitc = 0, byte_no = 0;
  logic scl_q = 1'b1, sda_q = 1'b1, rd = 1'b0, rd_end = 1'b0, nack_addr = 1'b0;
  logic [7:0] sh = 8'h00, tx = 8'h00;
  logic [7:0] wr_log[$];
  logic       mack_log[$];
  logic [7:0] rx_q[$];

  always @(scl or sda or rst_n) begin
    if (rst_n) begin
      slv_drv = 1'b0;
      bitc    = 0;
      rd      = 1'b0;
    end else if (scl_q === 1'b1 && scl === 1'b1 && sda_q === 1'b1 && sda === 1'b0) begin
      start_cnt++;
      bitc = 0; byte_no = 0; rd = 1'b0; rd_end = 1'b0; slv_drv = 1'b0;
    end else if (scl_q === 1'b1 && scl === 1'b1 && sda_q === 1'b0 && sda === 1'b1) begin
      stop_cnt++;
      bitc = 0; slv_drv = 1'b0;
    end else if (scl_q === 1'b0 && scl === 1'b1) begin
      if (bitc < 8) sh = {sh[6:0], sda};
      else if (rd && byte_no > 0) begin
        mack_log.push_back(sda);
        if (sda === 1'b1) rd_end = 1'b1;
      end
      bitc++;
    end else if (scl_q === 1'b1 && scl === 1'b0) begin
      scl_fall++;
      if (bitc == 8) begin
        if (!rd || byte_no == 0) begin
          wr_log.push_back(sh);
          if (byte_no == 0) rd = sh[0];
          slv_drv = !(nack_addr && byte_no == 0);
        end else begin
          slv_drv = 1'b0;
        end
      end else if (bitc == 9) begin
        bitc = 0; byte_no++; slv_drv = 1'b0;
        if (rd && !rd_end && byte_no <= 14) begin
          tx = rd_tab[byte_no-1].slv_byte;
          slv_drv = !tx[7];
        end
      end else if (bitc > 0 && rd && byte_no > 0 && !rd_end) begin
        slv_drv = !tx[7-bitc];
      end
    end
    scl_q = scl;
    sda_q = sda;
  end

  always @(negedge clk) if (data_avalid === 1'b1) rx_q.push_back(data);

  int n_chk = 0, n_fail = 0;
  int wb, sb, pb, rb, mb, base;
  logic flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_scl"}, 32'(scl), 1);
    check({tag, "_sda"}, 32'(sda), 1);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_data_avalid"}, 32'(data_avalid), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_busy"}, 32'(busy_now), 0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b0;
  endtask

  task automatic pulse(input logic is_init);
    @(negedge clk);
    if (is_init) mpu_init = 1'b1; else mpu_transfer = 1'b1;
    @(negedge clk);
    mpu_init = 1'b0;
    mpu_transfer = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && busy_now !== 1'b0; i++) @(negedge clk);
    check(name, 32'(busy_now), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wr_tab[0] = '{8'h6B, 8'h00};
    wr_tab[1] = '{8'h19, 8'h07};
    wr_tab[2] = '{8'h1A, 8'h06};
    wr_tab[3] = '{8'h1B, 8'h18};
    wr_tab[4] = '{8'h1C, 8'h01};
    for (int i = 0; i < 14; i++) rd_tab[i] = '{8'(i), 8'(i), (i == 13)};

    do_reset();

    // transfer before init must be ignored entirely
    base = scl_fall;
    flag = 1'b0;
    pulse(1'b0);
    repeat (60) begin
      @(negedge clk);
      if (busy_now !== 1'b0) flag = 1'b1;
    end
    check("pre_init_busy", 32'(flag), 0);
    check("pre_init_scl_edges", scl_fall - base, 0);

    // init sequence, with a second init pulse while busy
    wb = wr_log.size(); sb = start_cnt; pb = stop_cnt;
    pulse(1'b1);
    check("init_busy_rise", 32'(busy_now), 1);
    repeat (100) @(negedge clk);
    pulse(1'b1);
    wait_idle("init_timeout", 20000);
    check("init_starts", start_cnt - sb, 5);
    check("init_stops", stop_cnt - pb, 5);
    check("init_bytes", wr_log.size() - wb, 15);
    if (wr_log.size() - wb == 15) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("init%0d_addr", i), 32'(wr_log[wb+3*i]), 32'hD0);
        check($sformatf("init%0d_reg", i), 32'(wr_log[wb+3*i+1]), 32'(wr_tab[i].reg_a));
        check($sformatf("init%0d_val", i), 32'(wr_log[wb+3*i+2]), 32'(wr_tab[i].val));
      end
    end
    check("init_done", 32'(init_done), 1);

    // burst read
    wb = wr_log.size(); sb = start_cnt; pb = stop_cnt; rb = rx_q.size(); mb = mack_log.size();
    pulse(1'b0);
    check("xfer_busy_rise", 32'(busy_now), 1);
    wait_idle("xfer_timeout", 20000);
    check("xfer_strobes", rx_q.size() - rb, 14);
    check("xfer_macks", mack_log.size() - mb, 14);
    if (rx_q.size() - rb == 14 && mack_log.size() - mb == 14) begin
      for (int i = 0; i < 14; i++) begin
        check($sformatf("xfer_data%0d", i), 32'(rx_q[rb+i]), 32'(rd_tab[i].exp_data));
        check($sformatf("xfer_mack%0d", i), 32'(mack_log[mb+i]), 32'(rd_tab[i].exp_mack));
      end
    end
    check("xfer_wbytes", wr_log.size() - wb, 3);
    if (wr_log.size() - wb == 3) begin
      check("xfer_waddr", 32'(wr_log[wb]), 32'hD0);
      check("xfer_reg", 32'(wr_log[wb+1]), 32'h3B);
      check("xfer_raddr", 32'(wr_log[wb+2]), 32'hD1);
    end
    check("xfer_starts", start_cnt - sb, 2);
    check("xfer_stops", stop_cnt - pb, 1);
    check("xfer_init_done_kept", 32'(init_done), 1);

    // slave NACKs every address byte
    do_reset();
    nack_addr = 1'b1;
    sb = start_cnt; pb = stop_cnt;
    pulse(1'b1);
    wait_idle("nack_timeout", 20000);
`ifdef MPU_ACK_CHECK_EN
    check("nack_starts", start_cnt - sb, 1);
    check("nack_stops", stop_cnt - pb, 1);
    check("nack_init_done", 32'(init_done), 0);
`else
    check("nack_starts", start_cnt - sb, 5);
    check("nack_stops", stop_cnt - pb, 5);
    check("nack_init_done", 32'(init_done), 1);
`endif
    nack_addr = 1'b0;

    // reset in the middle of the 3rd init frame
    do_reset();
    sb = start_cnt;
    pulse(1'b1);
    for (int i = 0; i < 20000 && start_cnt - sb < 3; i++) @(negedge clk);
    check("midrst_reach_f3", 32'(start_cnt - sb >= 3), 1);
    repeat (30) @(negedge clk);
    check("midrst_busy_before", 32'(busy_now), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b0;
    base = scl_fall;
    repeat (60) @(negedge clk);
    check("midrst_bus_quiet", scl_fall - base, 0);
    check("midrst_init_done", 32'(init_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
